// File: rtl/divide_ctrl_pkg.sv
// divide_ctrl shared definitions.
// Mode codes, FSM states and the config validity rule.
package divide_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STOP  = 2'd0;
  localparam mode_t MODE_CONT  = 2'd1;
  localparam mode_t MODE_BURST = 2'd2;
  localparam mode_t MODE_RSVD  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Operands are zero-extended to 32 bits by the caller.
  function automatic logic cfg_ok(
    input logic [31:0] m,
    input logic [31:0] n,
    input mode_t       mode,
    input logic [31:0] count
  );
    logic burstBad;
    burstBad = (mode == MODE_BURST) &&
               (count == 32'd0);
    cfg_ok = (m >= 32'd2) &&
             (n >= 32'd1) &&
             (n <= m) &&
             (mode != MODE_RSVD) &&
             !burstBad;
  endfunction

endpackage

// File: rtl/divide_ctrl_if.sv
// Configuration channel of the clock-divider controller.
// Valid/ready offer of M/N/mode/count plus the reject pulse.
interface divide_ctrl_if
  import divide_ctrl_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 8
) ();

  logic               cfgValid;
  logic               cfgReady;
  logic [CNT_W-1:0]   cfgM;
  logic [CNT_W-1:0]   cfgN;
  mode_t              cfgMode;
  logic [BURST_W-1:0] cfgCount;
  logic               cfgErr;

  modport master (
    output cfgValid,
    output cfgM,
    output cfgN,
    output cfgMode,
    output cfgCount,
    input  cfgReady,
    input  cfgErr
  );

  modport slave (
    input  cfgValid,
    input  cfgM,
    input  cfgN,
    input  cfgMode,
    input  cfgCount,
    output cfgReady,
    output cfgErr
  );

endinterface

// File: rtl/divide_ctrl_period_cnt.sv
// 1..M period counter with the active M/N registers.
// Produces the registered divided waveform and period tick.
module period_cnt
  import divide_ctrl_pkg::*;
#(
  parameter int CNT_W = 24,
  parameter int DEF_M = 10_000_000,
  parameter int DEF_N = 5_000_000
) (
  input  logic             clkI,
  input  logic             enable,
  input  logic             run,
  input  logic             load,
  input  logic [CNT_W-1:0] loadM,
  input  logic [CNT_W-1:0] loadN,
  output logic             atBoundary,
  output logic             waveO,
  output logic             tickO
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r;
  logic [CNT_W-1:0] actM;
  logic [CNT_W-1:0] actN;

  assign atBoundary = (r == actM);

  // New M/N only ever arrive together with r=1, so r never exceeds M.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      r    <= ONE;
      actM <= CNT_W'(DEF_M);
      actN <= CNT_W'(DEF_N);
    end else if (load) begin
      r    <= ONE;
      actM <= loadM;
      actN <= loadN;
    end else if (run) begin
      r <= atBoundary ? ONE : r + ONE;
    end
  end

  // Outputs use the values of the cycle just ending, so a final
  // boundary still drives its high level before going quiet.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      waveO <= 1'b0;
      tickO <= 1'b0;
    end else begin
      waveO <= run && ((r >= actN) || atBoundary);
      tickO <= run && (r == ONE);
    end
  end

endmodule

// File: rtl/divide_ctrl.sv
// Run-time controller for the programmable clock divider.
// Validates configs and swaps them in only on period boundaries.
module divide_ctrl
  import divide_ctrl_pkg::*;
#(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 8,
  parameter int DEF_M   = 10_000_000,
  parameter int DEF_N   = 5_000_000
) (
  input  logic         clkI,
  input  logic         enable,
  divide_ctrl_if.slave cfg,
  output logic         waveO,
  output logic         tickO,
  output logic         busy,
  output logic         doneO
);

  state_t state;
  state_t stateNxt;

  logic               pendV;
  logic               pendVNxt;
  logic [CNT_W-1:0]   pendM;
  logic [CNT_W-1:0]   pendMNxt;
  logic [CNT_W-1:0]   pendN;
  logic [CNT_W-1:0]   pendNNxt;
  mode_t              pendMode;
  mode_t              pendModeNxt;
  logic [BURST_W-1:0] pendCnt;
  logic [BURST_W-1:0] pendCntNxt;

  mode_t              actMode;
  mode_t              actModeNxt;
  logic [BURST_W-1:0] remain;
  logic [BURST_W-1:0] remainNxt;

  logic errQ;
  logic errNxt;
  logic doneQ;
  logic doneNxt;

  logic             load;
  logic [CNT_W-1:0] loadM;
  logic [CNT_W-1:0] loadN;
  logic             atBoundary;

  logic hs;
  logic ok;
  logic accept;
  logic endStop;
  logic swap;
  logic inBurst;
  logic burstEnd;
  logic burstStep;

  assign hs     = cfg.cfgValid && !pendV;
  assign ok     = cfg_ok(32'(cfg.cfgM),
                         32'(cfg.cfgN),
                         cfg.cfgMode,
                         32'(cfg.cfgCount));
  assign accept = hs && ok;

  // A pending config always outranks the remaining burst periods.
  assign endStop   = pendV && (pendMode == MODE_STOP);
  assign swap      = pendV && (pendMode != MODE_STOP);
  assign inBurst   = !pendV && (actMode == MODE_BURST);
  assign burstEnd  = inBurst && (remain == BURST_W'(1));
  assign burstStep = inBurst && (remain != BURST_W'(1));

  assign cfg.cfgReady = !pendV;
  assign cfg.cfgErr   = errQ;
  assign busy         = (state == ST_RUN);
  assign doneO        = doneQ;

  period_cnt #(
    .CNT_W (CNT_W),
    .DEF_M (DEF_M),
    .DEF_N (DEF_N)
  ) u_cnt (
    .clkI       (clkI),
    .enable     (enable),
    .run        (busy),
    .load       (load),
    .loadM      (loadM),
    .loadN      (loadN),
    .atBoundary (atBoundary),
    .waveO      (waveO),
    .tickO      (tickO)
  );

  // FSM state register.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) state <= ST_IDLE;
    else         state <= stateNxt;
  end

  // Pending slot, held until the next period boundary.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      pendV    <= 1'b0;
      pendM    <= '0;
      pendN    <= '0;
      pendMode <= MODE_STOP;
      pendCnt  <= '0;
    end else begin
      pendV    <= pendVNxt;
      pendM    <= pendMNxt;
      pendN    <= pendNNxt;
      pendMode <= pendModeNxt;
      pendCnt  <= pendCntNxt;
    end
  end

  // Active mode and remaining burst periods.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      actMode <= MODE_STOP;
      remain  <= '0;
    end else begin
      actMode <= actModeNxt;
      remain  <= remainNxt;
    end
  end

  // One-cycle reject and done pulses.
  always_ff @(posedge clkI or negedge enable) begin
    if (!enable) begin
      errQ  <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      errQ  <= errNxt;
      doneQ <= doneNxt;
    end
  end

  // Next-state, slot and load decisions.
  always_comb begin
    stateNxt    = state;
    pendVNxt    = pendV;
    pendMNxt    = pendM;
    pendNNxt    = pendN;
    pendModeNxt = pendMode;
    pendCntNxt  = pendCnt;
    actModeNxt  = actMode;
    remainNxt   = remain;
    errNxt      = hs && !ok;
    doneNxt     = 1'b0;
    load        = 1'b0;
    loadM       = cfg.cfgM;
    loadN       = cfg.cfgN;

    unique case (state)
      ST_IDLE: begin
        // A slot left over from the last edge of RUN starts here.
        if (pendV) begin
          pendVNxt = 1'b0;
          if (pendMode != MODE_STOP) begin
            load       = 1'b1;
            loadM      = pendM;
            loadN      = pendN;
            actModeNxt = pendMode;
            remainNxt  = pendCnt;
            stateNxt   = ST_RUN;
          end
        end else if (accept &&
                     cfg.cfgMode != MODE_STOP) begin
          load       = 1'b1;
          actModeNxt = cfg.cfgMode;
          remainNxt  = cfg.cfgCount;
          stateNxt   = ST_RUN;
        end
      end

      ST_RUN: begin
        if (accept) begin
          pendVNxt    = 1'b1;
          pendMNxt    = cfg.cfgM;
          pendNNxt    = cfg.cfgN;
          pendModeNxt = cfg.cfgMode;
          pendCntNxt  = cfg.cfgCount;
        end
        if (atBoundary) begin
          unique case (1'b1)
            endStop: begin
              pendVNxt = 1'b0;
              stateNxt = ST_IDLE;
              doneNxt  = 1'b1;
            end
            swap: begin
              pendVNxt   = 1'b0;
              load       = 1'b1;
              loadM      = pendM;
              loadN      = pendN;
              actModeNxt = pendMode;
              remainNxt  = pendCnt;
            end
            burstEnd: begin
              stateNxt = ST_IDLE;
              doneNxt  = 1'b1;
            end
            burstStep: begin
              remainNxt = remain - BURST_W'(1);
            end
            default: ;
          endcase
        end
      end

      default: stateNxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/divide_ctrl.md
# divide_ctrl

Run-time controller for the programmable clock-divider datapath. Accepts period/duty/mode configurations over a valid/ready handshake and validates them. Applies each one only at a period boundary, so the divided waveform never glitches. Runs the 1..M period counter in continuous or burst mode. Sits between the control FSM and the divider-driven peripherals (blinkers, buzzers, scan clocks) and replaces hard-wired M/N parameters.

## Interface
- CNT_W, 24: width of period (M) and threshold (N) values.
- BURST_W, 8: width of the burst period count.
- DEF_M, 10_000_000: active M after reset.
- DEF_N, 5_000_000: active N after reset.

- clkI  in  1  system clock, all logic on posedge.
- enable  in  1  asynchronous, active-low reset; low clears every register immediately.
- cfgValid  in  1  configuration offered.
- cfgReady  out  1  controller can take a configuration; equals !pending.
- cfgM  in  CNT_W  period length in cycles.
- cfgN  in  CNT_W  high threshold.
- cfgMode  in  2  0 = STOP, 1 = CONT, 2 = BURST, 3 = reserved (invalid).
- cfgCount  in  BURST_W  number of periods for BURST.
- cfgErr  out  1  one-cycle pulse: handshaken configuration rejected.
- waveO  out  1  divided waveform, registered.
- tickO  out  1  one-cycle pulse at the start of each period.
- busy  out  1  high while in RUN.
- doneO  out  1  one-cycle pulse on every RUN→IDLE transition.

## Operation
- States are IDLE and RUN. Reset puts the block in IDLE with active M/N = DEF_M/DEF_N, counter r=1, and no pending configuration.
- Reset values: waveO=0, tickO=0, busy=0, doneO=0, cfgErr=0, cfgReady=1.
- A handshake is cfgValid && cfgReady. Every handshake consumes the configuration, valid or not.
- Validation rules: M ≥ 2, 1 ≤ N ≤ M, mode ≠ 3, and cfgCount ≥ 1 when mode is BURST. If any rule fails, cfgErr pulses on the next cycle, the configuration is dropped, and state is unchanged.
- In IDLE, a valid CONT or BURST configuration loads at once: r=1, burst remaining = cfgCount, next state RUN. A valid STOP in IDLE is accepted with no effect and no doneO.
- In RUN, a valid configuration is latched as pending, which drops cfgReady. It takes effect on the boundary edge (r==M):
  - STOP: go to IDLE.
  - CONT or BURST: stay in RUN, load the new M/N/mode/count, set r=1.
- The pending slot then clears, and cfgReady returns to 1 on the following cycle.
- Counter in RUN: if r==M then r←1, else r←r+1. The period is exactly M cycles.
- Registered outputs in RUN:
  - waveO ← (r ≥ N) || (r == M), using the active N and M.
  - tickO ← (r == 1).
- In IDLE, waveO←0 and tickO←0.
- BURST: remaining decrements on each boundary edge. The boundary edge where remaining==1 goes to IDLE and pulses doneO, unless a pending CONT or BURST configuration exists, in which case the new configuration wins and there is no doneO.
- A pending configuration always overrides the remaining burst periods at the next boundary.

## Timing
- Start latency: handshake at edge t → RUN with r=1 after t → tickO=1 after edge t+1.
- Reconfiguration in RUN is never mid-period. The new M/N first affect waveO one edge after the boundary edge.
- On the final boundary (STOP or burst end), waveO is still driven high for that r==M cycle. waveO is 0 from the next edge, and doneO pulses in the same cycle as that final high.
- cfgErr and doneO are registered pulses, exactly 1 cycle wide.
- If enable is asserted low mid-period, outputs go to reset values asynchronously and any pending configuration is lost.
- Arithmetic: all compares are unsigned CNT_W-bit. r never exceeds M, because a new M is only loaded together with r=1.

## Structure
- divide_ctrl_pkg holds:
  - mode constants MODE_STOP/MODE_CONT/MODE_BURST;
  - state encoding ST_IDLE/ST_RUN;
  - a function cfg_ok(M, N, mode, count) shared by RTL and bench.
- One sub-module, period_cnt: counter r, the active M/N registers, and the waveO/tickO registers. It has a load strobe and an at_boundary output.
- divide_ctrl itself holds the FSM, the pending slot, and the burst counter.

## Test plan
- Reset, then valid CONT M=4, N=3 → tickO on cycles 2, 6, 10 after the handshake; waveO repeats 0,0,1,1.
- BURST M=4, N=2, count=3 → exactly 3 tickO pulses. doneO coincides with the 12th waveO cycle (high), busy falls, waveO=0 afterwards.
- In CONT M=8, N=4, send M=4, N=3 at r=2 → cfgReady low until the boundary; old pattern completes its 8 cycles, then the new 4-cycle pattern runs with no short or long period.
- Send M=1, then N=0, then mode=3, then BURST with count=0 → four cfgErr pulses; waveO and busy unchanged.
- Send STOP during CONT M=6 → RUN persists to r==6, then doneO pulses and waveO goes 0. STOP in IDLE → no doneO.
- Pull enable low at r=3 of a burst → all outputs reset immediately and cfgReady=1; after release the block is in IDLE with DEF_M/DEF_N active.
